// File: rtl/cosine_sim_search_ctrl.sv
// Best-match search sequencer around one shared cosine similarity unit (CSU).
// Walks req_count candidates starting at req_base (addresses wrap modulo
// 2^IDX_W), runs the CSU once per candidate, keeps a strict FP16 argmax that
// skips NaN results, and returns index/score/match/timeout over valid/ready.
module cosine_sim_search_ctrl #(
    parameter int IDX_W          = 8,
    parameter int LOAD_LAT       = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_base,
    input  logic [IDX_W:0]   req_count,
    input  logic [15:0]      req_threshold,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDX_W-1:0] rsp_best_idx,
    output logic [15:0]      rsp_best_sim,
    output logic             rsp_found,
    output logic             rsp_match,
    output logic             rsp_timeout,
    output logic             op_load,
    output logic [IDX_W-1:0] op_addr,
    output logic             csu_start,
    input  logic             csu_done,
    input  logic [15:0]      csu_similarity,
    output logic             busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LOAD,
        S_START,
        S_WAIT_DONE,
        S_COMPARE,
        S_RESP
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] base;
    logic [IDX_W:0]   count;
    logic [IDX_W:0]   k;
    logic [15:0]      threshold;
    logic [2:0]       lat_cnt;
    logic [TW-1:0]    to_cnt;
    logic [15:0]      sim_cap;
    logic [15:0]      best_sim;
    logic [IDX_W-1:0] best_idx;
    logic             found;
    logic             timeout_flag;
    logic             last_cand;
    logic             to_expired;

    function automatic logic fp16_is_nan(input logic [15:0] h);
        return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
    endfunction

    // Sign-magnitude to signed key: -0 and +0 both map to 0, Inf orders naturally.
    function automatic logic fp16_gt(input logic [15:0] a, input logic [15:0] b);
        logic signed [16:0] ka;
        logic signed [16:0] kb;
        ka = a[15] ? -$signed({2'b00, a[14:0]}) : $signed({2'b00, a[14:0]});
        kb = b[15] ? -$signed({2'b00, b[14:0]}) : $signed({2'b00, b[14:0]});
        return ka > kb;
    endfunction

    assign last_cand = (k == count - (IDX_W+1)'(1));
    // Abort so rsp_timeout rises exactly TIMEOUT_CYCLES cycles after the csu_start cycle.
    assign to_expired = (to_cnt == TW'(TIMEOUT_CYCLES - 2));

    assign op_addr      = base + k[IDX_W-1:0];
    assign rsp_best_idx = best_idx;
    assign rsp_best_sim = best_sim;
    assign rsp_found    = found;
    assign rsp_match    = found && !fp16_is_nan(threshold) && fp16_gt(best_sim, threshold);
    assign rsp_timeout  = timeout_flag;
    assign busy         = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake/strobe outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        op_load    = 1'b0;
        csu_start  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = (req_count == '0) ? S_RESP : S_LOAD;
            end
            S_LOAD: begin
                op_load    = 1'b1;
                state_next = S_WAIT_LOAD;
            end
            S_WAIT_LOAD: begin
                if (lat_cnt == 3'(LOAD_LAT - 1)) state_next = S_START;
            end
            S_START: begin
                csu_start  = 1'b1;
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (csu_done)        state_next = S_COMPARE;
                else if (to_expired) state_next = S_RESP;
            end
            S_COMPARE: begin
                state_next = last_cand ? S_RESP : S_LOAD;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request latch, counters, result capture and running argmax.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base         <= '0;
            count        <= '0;
            threshold    <= '0;
            k            <= '0;
            lat_cnt      <= '0;
            to_cnt       <= '0;
            sim_cap      <= '0;
            best_sim     <= '0;
            best_idx     <= '0;
            found        <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        base         <= req_base;
                        count        <= req_count;
                        threshold    <= req_threshold;
                        k            <= '0;
                        best_sim     <= '0;
                        best_idx     <= '0;
                        found        <= 1'b0;
                        timeout_flag <= 1'b0;
                    end
                end
                S_LOAD:      lat_cnt <= '0;
                S_WAIT_LOAD: lat_cnt <= lat_cnt + 3'd1;
                S_START:     to_cnt  <= '0;
                S_WAIT_DONE: begin
                    if (csu_done) begin
                        sim_cap <= csu_similarity;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                        if (to_expired) timeout_flag <= 1'b1;
                    end
                end
                S_COMPARE: begin
                    if (!fp16_is_nan(sim_cap) && (!found || fp16_gt(sim_cap, best_sim))) begin
                        best_sim <= sim_cap;
                        best_idx <= op_addr;
                        found    <= 1'b1;
                    end
                    if (!last_cand) k <= k + (IDX_W+1)'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cosine_sim_search_ctrl.md
Name: cosine_sim_search_ctrl

Overview:
- Sequencer that owns one shared cosine similarity unit (CSU) and runs a best-match search over a contiguous range of candidate tokens.
- Per candidate: loads CSU operand registers through an external operand fetch port, pulses CSU start, waits for done, then folds the FP16 result into a running argmax.
- Returns best index, best score and a threshold-match flag over a valid/ready response.

Parameters:
- IDX_W, 8, width of candidate index/address.
- LOAD_LAT, 1, cycles from op_load to operands stable at CSU inputs (1..7).
- TIMEOUT_CYCLES, 64, max cycles waiting for csu_done before aborting (must be > 34).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  search request valid.
- req_ready  out  1  high only in IDLE.
- req_base  in  IDX_W  first candidate index.
- req_count  in  IDX_W+1  number of candidates (0 legal).
- req_threshold  in  16  FP16 match threshold.
- rsp_valid  out  1  result valid, held until rsp_ready.
- rsp_ready  in  1  result accepted.
- rsp_best_idx  out  IDX_W  index of best candidate.
- rsp_best_sim  out  16  FP16 best similarity.
- rsp_found  out  1  at least one non-NaN result seen.
- rsp_match  out  1  rsp_found and best_sim > threshold (strict).
- rsp_timeout  out  1  search aborted on CSU timeout.
- op_load  out  1  one-cycle pulse: fetch candidate operands.
- op_addr  out  IDX_W  candidate index for op_load.
- csu_start  out  1  one-cycle CSU start pulse.
- csu_done  in  1  CSU done pulse.
- csu_similarity  in  16  CSU result, sampled only when csu_done=1.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: state IDLE; req_ready=1; all other outputs 0, including rsp_best_idx and rsp_best_sim, all counters and latched request fields.
- States and transitions:
  - IDLE: on req_valid&&req_ready, latch base/count/threshold, clear best (found=0, sim=0, idx=0).
    - count==0: go to RESP.
    - otherwise: go to LOAD.
  - LOAD: op_load=1, op_addr=(base+k) mod 2^IDX_W, where k is the candidate counter; go to WAIT_LOAD.
  - WAIT_LOAD: wait LOAD_LAT cycles, then go to START.
  - START: csu_start=1 for exactly one cycle; clear timeout counter; go to WAIT_DONE.
  - WAIT_DONE:
    - On csu_done: capture csu_similarity; go to COMPARE.
    - If the counter reaches TIMEOUT_CYCLES first: set timeout flag; go to RESP.
  - COMPARE: update best.
    - k==count-1: go to RESP.
    - Otherwise: k++ and go to LOAD.
  - RESP: rsp_valid=1 with stable fields; on rsp_ready, clear rsp_valid and go to IDLE the next cycle.
- Minimum per-candidate cost: 1 (LOAD) + LOAD_LAT + 1 (START) + CSU latency + 1 (COMPARE).
- FP16 compare rules:
  - NaN is exp==31 && mant!=0; NaN results are skipped and never update best.
  - +0 and -0 compare equal.
  - ±Inf are ordered normally.
  - Ordering is sign-magnitude: negative < positive, larger magnitude is more negative.
- Argmax update:
  - Replace only if !found or new > best (strict), so ties keep the lowest k.
  - rsp_best_idx holds the absolute wrapped address, not k.
- rsp_match = found && best_sim > threshold under the same compare. A NaN threshold gives rsp_match=0.
- Timeout:
  - rsp_timeout=1; best reflects candidates completed so far.
  - No further csu_start is issued.
  - A late csu_done arriving after the abort is ignored in RESP/IDLE.
- csu_done outside WAIT_DONE is ignored.
- req_valid outside IDLE is not accepted (req_ready=0).
- Full range: req_count=2^IDX_W is legal and visits every index once.
- Wrap-around: addresses wrap modulo 2^IDX_W.
- Reset mid-operation: immediate return to IDLE with reset values; any pending CSU result is discarded.

Test Plan:
- base=4, count=3; CSU returns 0x3800 (0.5), 0x3A00 (0.75), 0xB800 (-0.5); threshold 0x3800 -> op_addr sequence 4,5,6; rsp_best_idx=5, best_sim=0x3A00, found=1, match=1, timeout=0.
- count=0 -> no op_load/csu_start; rsp_valid within 2 cycles of accept; found=0, match=0, best_sim=0x0000.
- base=0xFE, count=3; results 0x3C00, 0x7E00 (NaN), 0x3C00 -> addresses FE, FF, 00; NaN skipped; tie keeps idx=0xFE, best_sim=0x3C00.
- base=10, count=2; first done after 34 cycles, second never arrives -> rsp_timeout=1 exactly TIMEOUT_CYCLES after second csu_start; best_idx=10; stray later csu_done ignored.
- rsp_ready held low 5 cycles -> rsp_valid and all rsp fields stable; req_ready=0 throughout; new request accepted only after the handshake completes.
- rst_n asserted during WAIT_DONE of a 4-candidate search -> all outputs at reset values asynchronously; a fresh request then completes normally.
